// File: rtl/mux_req_arbiter_if.sv
// Handshake and mux-drive bundle for mux_req_arbiter.
// master = requesters plus downstream mux side, slave = arbiter.
interface mux_req_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid1;
    logic             in_valid2;
    logic             in_valid3;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic             in_ready1;
    logic             in_ready2;
    logic             in_ready3;
    logic             hold;
    logic [WIDTH-1:0] ip1;
    logic [WIDTH-1:0] ip2;
    logic [WIDTH-1:0] ip3;
    logic             sel1;
    logic             sel2;
    logic             sel3;
    logic [CNT_W-1:0] grant_cnt;

    modport master (
        output in_valid1, in_valid2, in_valid3,
        output in_data1, in_data2, in_data3,
        output hold,
        input  in_ready1, in_ready2, in_ready3,
        input  ip1, ip2, ip3,
        input  sel1, sel2, sel3,
        input  grant_cnt
    );

    modport slave (
        input  in_valid1, in_valid2, in_valid3,
        input  in_data1, in_data2, in_data3,
        input  hold,
        output in_ready1, in_ready2, in_ready3,
        output ip1, ip2, ip3,
        output sel1, sel2, sel3,
        output grant_cnt
    );
endinterface

// File: rtl/mux_req_arbiter.sv
// Round-robin feeder for the 3-input registered priority mux.
// Define MUX_ARB_SVA_EN to compile in protocol assertions.
module mux_req_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic              clock,
    input logic              reset_n,
    mux_req_arbiter_if.slave bus
);
    logic [2:0]       bv;
    logic [2:0]       vin;
    logic [2:0]       acc;
    logic [2:0]       gnt;
    logic [1:0]       last;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] b3;

    assign vin = {bus.in_valid3, bus.in_valid2, bus.in_valid1};
    assign acc = vin & ~bv;

    assign bus.in_ready1 = ~bv[0];
    assign bus.in_ready2 = ~bv[1];
    assign bus.in_ready3 = ~bv[2];

    // Search starts just after the last winner; last is always 1..3.
    always_comb begin
        gnt = 3'b000;
        if (!bus.hold) begin
            unique case (last)
                2'd1: begin
                    if (bv[1])      gnt = 3'b010;
                    else if (bv[2]) gnt = 3'b100;
                    else if (bv[0]) gnt = 3'b001;
                end
                2'd2: begin
                    if (bv[2])      gnt = 3'b100;
                    else if (bv[0]) gnt = 3'b001;
                    else if (bv[1]) gnt = 3'b010;
                end
                default: begin
                    if (bv[0])      gnt = 3'b001;
                    else if (bv[1]) gnt = 3'b010;
                    else if (bv[2]) gnt = 3'b100;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bv            <= 3'b000;
            b1            <= '0;
            b2            <= '0;
            b3            <= '0;
            last          <= 2'd3;
            bus.ip1       <= '0;
            bus.ip2       <= '0;
            bus.ip3       <= '0;
            bus.sel1      <= 1'b0;
            bus.sel2      <= 1'b0;
            bus.sel3      <= 1'b0;
            bus.grant_cnt <= '0;
        end else begin
            // gnt only hits full buffers, acc only empty ones.
            bv <= (bv & ~gnt) | acc;
            if (acc[0]) b1 <= bus.in_data1;
            if (acc[1]) b2 <= bus.in_data2;
            if (acc[2]) b3 <= bus.in_data3;
            bus.sel1 <= gnt[0];
            bus.sel2 <= gnt[1];
            bus.sel3 <= gnt[2];
            if (gnt[0]) bus.ip1 <= b1;
            if (gnt[1]) bus.ip2 <= b2;
            if (gnt[2]) bus.ip3 <= b3;
            if (|gnt) begin
                bus.grant_cnt <= bus.grant_cnt + 1'b1;
                if (gnt[0])      last <= 2'd1;
                else if (gnt[1]) last <= 2'd2;
                else             last <= 2'd3;
            end
        end
    end

`ifdef MUX_ARB_SVA_EN
    logic [2:0] stall;
    logic [2:0] sc [3];

    assign stall = vin & bv & {3{~bus.hold}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) sc[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!stall[k])          sc[k] <= '0;
                else if (sc[k] < 3'd4) sc[k] <= sc[k] + 1'b1;
            end
        end
    end

    a_onehot: assert property (
        @(posedge clock) disable iff (!reset_n)
        $onehot0({bus.sel1, bus.sel2, bus.sel3})
    ) else $warning("sel not onehot0");

    a_ip1: assert property (
        @(posedge clock) disable iff (!reset_n)
        bus.sel1 |-> bus.ip1 == $past(b1)
    ) else $warning("ip1 not buffered word");

    a_ip2: assert property (
        @(posedge clock) disable iff (!reset_n)
        bus.sel2 |-> bus.ip2 == $past(b2)
    ) else $warning("ip2 not buffered word");

    a_ip3: assert property (
        @(posedge clock) disable iff (!reset_n)
        bus.sel3 |-> bus.ip3 == $past(b3)
    ) else $warning("ip3 not buffered word");

    a_starve: assert property (
        @(posedge clock) disable iff (!reset_n)
        sc[0] < 3'd4 && sc[1] < 3'd4 && sc[2] < 3'd4
    ) else $warning("requester starved");

    a_cnt: assert property (
        @(posedge clock) disable iff (!reset_n)
        bus.grant_cnt == $past(bus.grant_cnt) +
            CNT_W'(bus.sel1 | bus.sel2 | bus.sel3)
    ) else $warning("grant_cnt out of step");
`endif
endmodule
